// File: rtl/regfile_write_arbiter.sv
// Two-port register-file write arbiter.
// Each requester writes into its own small FIFO. One entry per cycle is popped,
// round-robin when both FIFOs hold work, and is registered onto the regfile
// write port. Writes to register 0 are consumed but never enabled. The
// pending vector marks every register with a write still queued or issuing.
module regfile_write_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       a_valid,
   output logic                       a_ready,
   input  logic [ADDR_WIDTH-1:0]      a_addr,
   input  logic [DATA_WIDTH-1:0]      a_data,
   input  logic                       b_valid,
   output logic                       b_ready,
   input  logic [ADDR_WIDTH-1:0]      b_addr,
   input  logic [DATA_WIDTH-1:0]      b_data,
   output logic                       we,
   output logic [ADDR_WIDTH-1:0]      writeaddr,
   output logic [DATA_WIDTH-1:0]      writedata,
   output logic [2**ADDR_WIDTH-1:0]   pending
);

   localparam int PTR_W = $clog2(DEPTH);

   // Port 0 is requester A, port 1 is requester B.
   logic [ADDR_WIDTH-1:0] q_addr  [2][DEPTH];
   logic [DATA_WIDTH-1:0] q_data  [2][DEPTH];
   logic [DEPTH-1:0]      q_valid [2];
   logic [PTR_W-1:0]      wr_ptr  [2];
   logic [PTR_W-1:0]      rd_ptr  [2];

   logic [ADDR_WIDTH-1:0] in_addr [2];
   logic [DATA_WIDTH-1:0] in_data [2];
   logic [1:0]            in_valid;
   logic [1:0]            full;
   logic [1:0]            nonempty;
   logic [1:0]            ready;
   logic [1:0]            push;
   logic [1:0]            pop_sel;
   logic                  last_grant;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_data;

   assign in_valid   = {b_valid, a_valid};
   assign in_addr[0] = a_addr;
   assign in_addr[1] = b_addr;
   assign in_data[0] = a_data;
   assign in_data[1] = b_data;
   assign a_ready    = ready[0];
   assign b_ready    = ready[1];

   // Occupancy flags and accept handshake; readiness reflects start-of-cycle fullness only, so a pop never frees a slot early.
   always_comb begin
      full     = '0;
      nonempty = '0;
      ready    = '0;
      push     = '0;
      for (int p = 0; p < 2; p++) begin
         full[p]     = &q_valid[p];
         nonempty[p] = |q_valid[p];
         ready[p]    = ~reset & ~full[p];
         push[p]     = in_valid[p] & ready[p];
      end
   end

   // Round-robin pop selection: a sole non-empty FIFO wins, otherwise the port not granted last time.
   always_comb begin
      pop_sel = 2'b00;
      if (nonempty[0] && nonempty[1]) begin
         if (last_grant) pop_sel = 2'b01;
         else            pop_sel = 2'b10;
      end else if (nonempty[0]) begin
         pop_sel = 2'b01;
      end else if (nonempty[1]) begin
         pop_sel = 2'b10;
      end
      head_addr = pop_sel[1] ? q_addr[1][rd_ptr[1]] : q_addr[0][rd_ptr[0]];
      head_data = pop_sel[1] ? q_data[1][rd_ptr[1]] : q_data[0][rd_ptr[0]];
   end

   // FIFO storage and pointers; slots are tracked by per-entry valid bits and pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int p = 0; p < 2; p++) begin
            q_valid[p] <= '0;
            wr_ptr[p]  <= '0;
            rd_ptr[p]  <= '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
               q_addr[p][wr_ptr[p]]  <= in_addr[p];
               q_data[p][wr_ptr[p]]  <= in_data[p];
               q_valid[p][wr_ptr[p]] <= 1'b1;
               wr_ptr[p]             <= wr_ptr[p] + 1'b1;
            end
            if (pop_sel[p]) begin
               q_valid[p][rd_ptr[p]] <= 1'b0;
               rd_ptr[p]             <= rd_ptr[p] + 1'b1;
            end
         end
      end
   end

   // Issue stage: register the popped entry for one cycle; register 0 is consumed with the enable held low.
   always_ff @(posedge clk) begin
      if (reset) begin
         we         <= 1'b0;
         writeaddr  <= '0;
         writedata  <= '0;
         last_grant <= 1'b1;
      end else begin
         we <= (|pop_sel) && (head_addr != '0);
         if (|pop_sel) begin
            writeaddr  <= head_addr;
            writedata  <= head_data;
            last_grant <= pop_sel[1];
         end
      end
   end

   // Pending scoreboard: every live FIFO entry plus the enabled issue slot, never for register 0.
   always_comb begin
      pending = '0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[p][i] && (q_addr[p][i] != '0)) pending[q_addr[p][i]] = 1'b1;
         end
      end
      if (we) pending[writeaddr] = 1'b1;
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed scenarios plus randomized
// traffic, checked by a scoreboard fed from a queue-based reference model.
module tb_regfile_write_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          a_valid, b_valid;
   logic          a_ready, b_ready;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_data, b_data;
   logic          we;
   logic [AW-1:0] writeaddr;
   logic [DW-1:0] writedata;
   logic [31:0]   pending;

   regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .we(we), .writeaddr(writeaddr), .writedata(writedata), .pending(pending)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   // Reference model: each requester queue holds {addr,data}; lastB records who was served most recently.
   logic [AW+DW-1:0] mqa[$];
   logic [AW+DW-1:0] mqb[$];
   logic [AW+DW-1:0] exp_q[$];
   bit               lastB = 1'b1;
   logic [31:0]      exp_pending = '0;
   logic [DW-1:0]    regs [32];
   bit               started = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // One clock cycle of stimulus; the model decides acceptance and the pop for the coming edge.
   task automatic applyStimulus(input logic rst,
                                input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                                input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                                output bit acc_a, output bit acc_b);
      bit pop_a, pop_b;
      logic [AW+DW-1:0] e;
      logic [AW+DW-1:0] issued;
      bit has_issue;
      reset = rst;
      a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd;
      #1;
      checkOutput("a_ready", a_ready, (!rst && mqa.size() < DEPTH));
      checkOutput("b_ready", b_ready, (!rst && mqb.size() < DEPTH));
      acc_a = !rst && av && (mqa.size() < DEPTH);
      acc_b = !rst && bv && (mqb.size() < DEPTH);
      pop_a = 0; pop_b = 0;
      if (!rst) begin
         if (mqa.size() > 0 && mqb.size() > 0) begin
            if (lastB) pop_a = 1; else pop_b = 1;
         end else if (mqa.size() > 0) pop_a = 1;
         else if (mqb.size() > 0) pop_b = 1;
      end
      @(posedge clk);
      #1;
      has_issue = 0;
      issued = '0;
      if (rst) begin
         mqa.delete();
         mqb.delete();
         lastB = 1'b1;
      end else begin
         if (pop_a) begin e = mqa.pop_front(); lastB = 1'b0; issued = e; has_issue = 1; end
         if (pop_b) begin e = mqb.pop_front(); lastB = 1'b1; issued = e; has_issue = 1; end
         if (has_issue && issued[AW+DW-1:DW] != 0) exp_q.push_back(issued);
         if (acc_a) mqa.push_back({aa, ad});
         if (acc_b) mqb.push_back({ba, bd});
      end
      exp_pending = '0;
      foreach (mqa[i]) if (mqa[i][AW+DW-1:DW] != 0) exp_pending[mqa[i][AW+DW-1:DW]] = 1'b1;
      foreach (mqb[i]) if (mqb[i][AW+DW-1:DW] != 0) exp_pending[mqb[i][AW+DW-1:DW]] = 1'b1;
      if (has_issue && issued[AW+DW-1:DW] != 0) exp_pending[issued[AW+DW-1:DW]] = 1'b1;
      started = 1'b1;
   endtask

   // Monitor: on every falling edge compare pending and consume the expected write if we is presented.
   always @(negedge clk) begin
      logic [AW+DW-1:0] e;
      if (started) begin
         checkOutput("pending", pending, exp_pending);
         checkOutput("we", we, (exp_q.size() != 0));
         if (we === 1'b1 && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("writeaddr", writeaddr, e[AW+DW-1:DW]);
            checkOutput("writedata", writedata, e[DW-1:0]);
            regs[writeaddr] = writedata;
         end else if (exp_q.size() != 0) begin
            exp_q.delete();
         end
      end
   end

   bit acc_a, acc_b;

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, acc_a, acc_b);
   endtask

   task automatic doReset();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, acc_a, acc_b);
   endtask

   initial begin
      bit ha, hb;
      logic [AW-1:0] haa, hba;
      logic [DW-1:0] had, hbd;
      bit rst;
      int bcount;

      doReset();
      doReset();
      checkOutput("reset_writeaddr", writeaddr, 0);
      checkOutput("reset_writedata", writedata, 0);
      checkOutput("reset_we", we, 0);

      // A-only single write
      applyStimulus(0, 1, 5'd3, 32'hDEADBEEF, 0, 0, 0, acc_a, acc_b);
      idle(3);

      // Simultaneous pairs after reset: A first, then B, twice
      doReset();
      applyStimulus(0, 1, 5'd5, 32'h11111111, 1, 5'd6, 32'h22222222, acc_a, acc_b);
      applyStimulus(0, 1, 5'd5, 32'h33333333, 1, 5'd6, 32'h44444444, acc_a, acc_b);
      idle(5);

      // B hammering: hold each request until accepted
      bcount = 0;
      for (int k = 0; k < 6; k++) begin
         applyStimulus(0, 1, 5'd9, 32'hA0 + k, 1, 5'd10, 32'hB0 + bcount, acc_a, acc_b);
         if (acc_b) bcount++;
      end
      idle(6);

      // Register 0 write is consumed silently, next write follows
      applyStimulus(0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, acc_a, acc_b);
      applyStimulus(0, 1, 5'd1, 32'h00000001, 0, 0, 0, acc_a, acc_b);
      idle(3);

      // Fill both FIFOs, then reset mid-stream
      for (int k = 0; k < 4; k++)
         applyStimulus(0, 1, 5'd12 + k, 32'h1000 + k, 1, 5'd20 + k, 32'h2000 + k, acc_a, acc_b);
      doReset();
      idle(4);

      // Same-address tie after reset: B's value must be the survivor
      doReset();
      applyStimulus(0, 1, 5'd7, 32'hAAAA0000, 1, 5'd7, 32'hBBBB0000, acc_a, acc_b);
      idle(4);
      checkOutput("reg7_final", regs[7], 32'hBBBB0000);

      // Randomized traffic with occasional reset; requests held until accepted
      ha = 0; hb = 0; haa = 0; hba = 0; had = 0; hbd = 0;
      for (int c = 0; c < 2000; c++) begin
         if (!ha && ($urandom_range(0, 2) != 0)) begin
            ha = 1; haa = AW'($urandom_range(0, 31)); had = $urandom;
         end
         if (!hb && ($urandom_range(0, 2) != 0)) begin
            hb = 1; hba = AW'($urandom_range(0, 31)); hbd = $urandom;
         end
         rst = ($urandom_range(0, 149) == 0);
         applyStimulus(rst, ha, haa, had, hb, hba, hbd, acc_a, acc_b);
         if (acc_a) ha = 0;
         if (acc_b) hb = 0;
      end
      idle(6);
      checkOutput("drained", exp_q.size(), 0);
      checkOutput("final_pending", pending, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
